hdb3_decoder: RTL
=================

// Module: hdb3_decoder
// PURPOSE
//  Receive-side HDB3 decoder, the inverse of the hdb3 encoder chain. Takes one
//  bipolar symbol per i_clk on a 2-bit rail code and recovers the NRZ bit.
//  It detects V pulses (same polarity as the previous non-zero pulse) and
//  zeroes each V together with its B, or the 000 that precede it.
//  Sits between the line-interface sampler and the downstream NRZ consumer.
// PARAMETERS
//  DLY     4   delay-line depth in symbols; fixed by the HDB3 4-zero substitution; do not override
// PORTS
//  i_clk          input   1  system clock; one symbol per rising edge
//  i_rst_n        input   1  asynchronous active-low reset
//  i_hdb3_code    input   2  symbol: 2'b01 = +1, 2'b10 = -1, 2'b00 = 0, 2'b11 illegal
//  o_data         output  1  decoded NRZ bit
//  o_valid        output  1  high once the delay line holds real symbols
//  o_err          output  1  one-cycle code-violation flag (see CONFIGURATION)
// BEHAVIOUR
//  Clock and reset
//  - One clock domain; reset is asynchronous and active-low.
//  - Reset values: o_data=0, o_valid=0, o_err=0, sr[3:0]=0, last_pol=+, pol_vld=0, fill_cnt=0.
//  Mark and V classification
//  - Non-zero symbol with pol_vld=0: treated as a mark (1). Set pol_vld=1 and last_pol=sym.
//  - Non-zero symbol, pol_vld=1, polarity != last_pol: mark (1). last_pol<=sym.
//  - Non-zero symbol, pol_vld=1, polarity == last_pol: this is a V. last_pol<=sym.
//  - Symbol 00 or 11: space (0); last_pol is unchanged.
//  Delay line sr[3:0]
//  - Normal cycle: sr<={sr[2:0],mark}; o_data<=sr[3].
//  - V cycle: o_data<=sr[3], then sr<=4'b0000.
//  - Clearing all of sr on a V removes the V itself and the B/0 symbols at t-1..t-3.
//  - A V and its B can never straddle the sr[3]->o_data boundary.
//  Latency and o_valid
//  - Latency is exactly 4 clocks: the symbol sampled at edge k drives o_data after edge k+4.
//  - fill_cnt (3b) increments each clock and saturates at 4.
//  - o_valid<=1 when fill_cnt==4, i.e. first asserted with symbol 0 on o_data.
//  Boundary cases
//  - A V as the first pulse after reset cannot be detected (pol_vld=0), so it decodes as 1.
//  - Back-to-back Vs (e.g. 000V000V) each clear sr independently.
//  - Reset mid-stream: all state returns to reset values immediately; the first 4 outputs after release are invalid.
// CONFIGURATION
//  HDB3_ERR_CHK_EN defined:
//  - o_err<=1 for one cycle when any of these occurs:
//    (a) i_hdb3_code==2'b11;
//    (b) a 4th consecutive zero symbol, tracked by a zero-run counter cleared on any pulse;
//    (c) a V with the same polarity as the previous V (last_v_pol, set by the first V after reset).
//  - Data path is unaffected by errors.
//  HDB3_ERR_CHK_EN undefined:
//  - o_err is tied to 0 and no zero-run or last_v_pol logic is built.
//  - The port is always present, so the bench and top level are unchanged.
// STRUCTURE
//  - Shared include hdb3_defs.vh: `HDB3_POS=2'b01, `HDB3_NEG=2'b10, `HDB3_ZERO=2'b00, `HDB3_ILL=2'b11.
//  - The encoder stages use the same include.
//  - Sub-module hdb3_v_detect: owns last_pol/pol_vld and, with the macro, the checks.
//    Outputs mark, is_v and err per cycle (combinational from the input plus its own regs).
//  - Top level: sr, o_data, fill_cnt, o_valid.
// TESTING
//  1 Reset: hold i_rst_n=0 with random codes -> o_data=0, o_valid=0, o_err=0 throughout.
//  2 Alternating marks: +1,-1,+1,-1 -> o_data 1,1,1,1 from cycle 4; o_valid rises with first symbol.
//  3 000V: +1,0,0,0,+1,-1 -> o_data 1,0,0,0,0,1.
//  4 B00V: +1,-1,+1,0,0,+1 -> o_data 1,1,0,0,0,0 (B and V both removed).
//  5 Encoder loopback: pluse -> encoder -> decoder, 10k random bits -> output equals input delayed, zero mismatches.
//  6 HDB3_ERR_CHK_EN: inject 2'b11, then 0,0,0,0, then two same-polarity Vs -> one o_err pulse per fault.
//    Without the macro, o_err stays 0.

Source files
------------

// File: rtl/hdb3_decoder_pkg.sv
// Shared HDB3 rail codes and the per-cycle classification record used by the decoder.
// Optional checks are enabled with `define HDB3_ERR_CHK_EN (see hdb3_v_detect).
package hdb3_decoder_pkg;

  localparam logic [1:0] HDB3_POS  = 2'b01;
  localparam logic [1:0] HDB3_NEG  = 2'b10;
  localparam logic [1:0] HDB3_ZERO = 2'b00;
  localparam logic [1:0] HDB3_ILL  = 2'b11;

  // Classification of the current symbol
  typedef struct packed {
    logic mark;
    logic is_v;
    logic err;
  } vdet_t;

  function automatic logic is_pulse(input logic [1:0] code);
    return (code == HDB3_POS) || (code == HDB3_NEG);
  endfunction

endpackage

// File: rtl/hdb3_v_detect.sv
// Classifies each symbol as mark / V / space from polarity history.
// With HDB3_ERR_CHK_EN defined it also flags illegal codes, zero runs >3 and repeated-polarity Vs.
module hdb3_v_detect
  import hdb3_decoder_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_code,
  output vdet_t      o_vd
);

  logic r_last_pol;   // 1 = positive
  logic r_pol_vld;
  logic w_pulse;
  logic w_pol;
  logic w_is_v;
  logic w_err;

  assign w_pulse = is_pulse(i_code);
  assign w_pol   = (i_code == HDB3_POS);
  assign w_is_v  = w_pulse && r_pol_vld && (w_pol == r_last_pol);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_pol <= 1'b1;
      r_pol_vld  <= 1'b0;
    end else if (w_pulse) begin
      r_last_pol <= w_pol;
      r_pol_vld  <= 1'b1;
    end
  end

`ifdef HDB3_ERR_CHK_EN
  logic [1:0] r_zrun;
  logic       r_last_v_pol;
  logic       r_v_seen;
  logic       w_zero;

  assign w_zero = (i_code == HDB3_ZERO);

  // Zero-run saturates at 3 so every zero beyond the third is flagged
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_zrun       <= 2'd0;
      r_last_v_pol <= 1'b0;
      r_v_seen     <= 1'b0;
    end else begin
      if (w_pulse)
        r_zrun <= 2'd0;
      else if (w_zero && (r_zrun != 2'd3))
        r_zrun <= r_zrun + 2'd1;
      if (w_is_v) begin
        r_v_seen     <= 1'b1;
        r_last_v_pol <= w_pol;
      end
    end
  end

  assign w_err = (i_code == HDB3_ILL)
               | (w_zero && (r_zrun == 2'd3))
               | (w_is_v && r_v_seen && (w_pol == r_last_v_pol));
`else
  assign w_err = 1'b0;
`endif

  assign o_vd.mark = w_pulse && !w_is_v;
  assign o_vd.is_v = w_is_v;
  assign o_vd.err  = w_err;

endmodule

// File: rtl/hdb3_decoder.sv
// HDB3 receive decoder: 4-symbol delay line that is wiped on every V to drop the substitution.
// Error flag is only live when HDB3_ERR_CHK_EN is defined; otherwise o_err is constant 0.
module hdb3_decoder
  import hdb3_decoder_pkg::*;
#(
  parameter int DLY = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_hdb3_code,
  output logic       o_data,
  output logic       o_valid,
  output logic       o_err
);

  vdet_t          w_vd;
  logic [DLY-1:0] r_sr;
  logic [2:0]     r_fill;

  hdb3_v_detect u_vdet (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_code  (i_hdb3_code),
    .o_vd    (w_vd)
  );

  // The oldest entry leaves before the wipe, so a V never reaches back past t-3
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr    <= '0;
      o_data  <= 1'b0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      r_fill  <= 3'd0;
    end else begin
      o_data <= r_sr[DLY-1];
      r_sr   <= w_vd.is_v ? '0 : {r_sr[DLY-2:0], w_vd.mark};
      if (r_fill != 3'(DLY))
        r_fill <= r_fill + 3'd1;
      o_valid <= (r_fill == 3'(DLY));
      o_err   <= w_vd.err;
    end
  end

endmodule
